// File: rtl/audio_sched_pkg.sv
// Shared constants, state and volume encodings for the audio sample scheduler.
package audio_sched_pkg;

    localparam int AUDIO_RATE   = 48000;
    localparam int CLK_HZ_PAL   = 31_527_954;
    localparam int CLK_HZ_NTSC  = 32_727_264;
    localparam int ACC_W        = 27;
    localparam int MUTE_SAMPLES = 64;
    localparam int MUTE_W       = $clog2(MUTE_SAMPLES + 1);

    // Two clk_audio edges per sample, so the accumulator advances by twice the rate.
    localparam logic [ACC_W-1:0] INC      = ACC_W'(2 * AUDIO_RATE);
    localparam logic [ACC_W-1:0] MOD_PAL  = ACC_W'(CLK_HZ_PAL);
    localparam logic [ACC_W-1:0] MOD_NTSC = ACC_W'(CLK_HZ_NTSC);

    typedef enum logic {
        S_MUTE = 1'b0,
        S_RUN  = 1'b1
    } sched_state_t;

    typedef enum logic [1:0] {
        VOL_MUTE  = 2'd0,
        VOL_QTR   = 2'd1,
        VOL_HALF  = 2'd2,
        VOL_UNITY = 2'd3
    } vol_t;

    // Clamp a 17-bit signed value into 16 bits.
    function automatic logic signed [15:0] sat16(input logic signed [16:0] a);
        logic signed [15:0] r;
        if (a[16] != a[15]) r = {a[16], {15{~a[16]}}};
        else                r = a[15:0];
        return r;
    endfunction

    // Power-of-two attenuation; shifts keep the sign.
    function automatic logic signed [15:0] vol_scale(input logic signed [15:0] s,
                                                     input logic [1:0] vol);
        logic signed [15:0] r;
        case (vol)
            VOL_MUTE: r = '0;
            VOL_QTR:  r = s >>> 2;
            VOL_HALF: r = s >>> 1;
            default:  r = s;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/audio_sat_vol.sv
// Per-channel sample conditioning: halve, saturate to 16 bits, apply volume.
module audio_sat_vol
    import audio_sched_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic signed [17:0] audio_in,
    input  logic        [1:0]  volume,
    output logic signed [15:0] sample_out
);

    logic signed [16:0] a17_q;
    logic signed [15:0] sat_q;

    // Three free-running stages; the capture register downstream picks the value it needs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a17_q      <= '0;
            sat_q      <= '0;
            sample_out <= '0;
        end else begin
            a17_q      <= 17'(audio_in >>> 1);
            sat_q      <= sat16(a17_q);
            sample_out <= vol_scale(sat_q, volume);
        end
    end

endmodule

// File: rtl/audio_sample_sched.sv
// Audio sample scheduler: fractional 48 kHz clock from the pixel clock, mute sequencing
// across video-mode changes, and a sample word held stable across each clk_audio rise.
//
//  state  | meaning
//  S_MUTE | words captured as zero; counting sample strobes down from MUTE_SAMPLES
//  S_RUN  | conditioned samples captured on each clk_audio fall
module audio_sample_sched
    import audio_sched_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ntscmode,
    input  logic signed [17:0] audio_l,
    input  logic signed [17:0] audio_r,
    input  logic        [1:0]  system_volume,
    output logic               clk_audio,
    output logic               sample_stb,
    output logic        [31:0] audio_sample_word,
    output logic               muted
);

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [ACC_W-1:0]  modulus;
    logic              ntsc_q;
    logic              started;
    logic              mode_chg;
    logic              toggle;
    sched_state_t      state;
    sched_state_t      state_nxt;
    logic [MUTE_W-1:0] mute_cnt;
    logic [MUTE_W-1:0] mute_cnt_nxt;
    logic signed [15:0] s3_l;
    logic signed [15:0] s3_r;

    audio_sat_vol u_sat_l (
        .clk        (clk),
        .reset_n    (reset_n),
        .audio_in   (audio_l),
        .volume     (system_volume),
        .sample_out (s3_l)
    );

    audio_sat_vol u_sat_r (
        .clk        (clk),
        .reset_n    (reset_n),
        .audio_in   (audio_r),
        .volume     (system_volume),
        .sample_out (s3_r)
    );

    // Wrap detection; a mode change suppresses the toggle so the new mode starts from phase 0.
    always_comb begin
        modulus  = ntscmode ? MOD_NTSC : MOD_PAL;
        acc_sum  = acc + INC;
        mode_chg = started && (ntscmode != ntsc_q);
        toggle   = !mode_chg && (acc_sum >= modulus);
    end

    // Phase accumulator; ntsc_q takes its first value on the first clock without flagging a change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            ntsc_q  <= 1'b0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            ntsc_q  <= ntscmode;
            if (mode_chg)    acc <= '0;
            else if (toggle) acc <= acc_sum - modulus;
            else             acc <= acc_sum;
        end
    end

    // Audio clock, rise strobe, and word capture on the fall so the word is settled before the next rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_audio         <= 1'b0;
            sample_stb        <= 1'b0;
            audio_sample_word <= '0;
        end else begin
            clk_audio  <= clk_audio ^ toggle;
            sample_stb <= toggle & ~clk_audio;
            if (toggle && clk_audio)
                audio_sample_word <= muted ? 32'h0 : {s3_l, s3_r};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_MUTE;
            mute_cnt <= MUTE_W'(MUTE_SAMPLES);
        end else begin
            state    <= state_nxt;
            mute_cnt <= mute_cnt_nxt;
        end
    end

    // FSM next state: mode change from any state restarts the mute window.
    always_comb begin
        state_nxt    = state;
        mute_cnt_nxt = mute_cnt;
        muted        = (state == S_MUTE);
        if (mode_chg) begin
            state_nxt    = S_MUTE;
            mute_cnt_nxt = MUTE_W'(MUTE_SAMPLES);
        end else begin
            case (state)
                S_MUTE: begin
                    if (sample_stb) begin
                        mute_cnt_nxt = mute_cnt - MUTE_W'(1);
                        if (mute_cnt == MUTE_W'(1)) state_nxt = S_RUN;
                    end
                end
                default: state_nxt = S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_sample_sched.sv
// Directed bench for audio_sample_sched: mute window, stb spacing, datapath words,
// mode-change restart and asynchronous reset.
module tb_audio_sample_sched;

    logic        clk;
    logic        reset_n;
    logic        ntscmode;
    logic [17:0] audio_l;
    logic [17:0] audio_r;
    logic [1:0]  system_volume;
    logic        clk_audio;
    logic        sample_stb;
    logic [31:0] audio_sample_word;
    logic        muted;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [17:0] l;
        logic [17:0] r;
        logic [1:0]  vol;
        logic [31:0] word;
        string       tag;
    } vec_t;

    audio_sample_sched dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .ntscmode          (ntscmode),
        .audio_l           (audio_l),
        .audio_r           (audio_r),
        .system_volume     (system_volume),
        .clk_audio         (clk_audio),
        .sample_stb        (sample_stb),
        .audio_sample_word (audio_sample_word),
        .muted             (muted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h (%0d) expected 0x%h (%0d)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_stb(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!sample_stb && n < 1500);
        if (!sample_stb) check_vec({tag, "_stb_timeout"}, 32'(sample_stb), 32'd1);
    endtask

    task automatic wait_fall(input string tag);
        int   n    = 0;
        logic prev;
        logic fell = 1'b0;
        do begin
            prev = clk_audio;
            step();
            n++;
            fell = prev && !clk_audio;
        end while (!fell && n < 1500);
        if (!fell) check_vec({tag, "_fall_timeout"}, 32'(fell), 32'd1);
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    initial begin
        vec_t vecs[5];
        int   last_stb;
        int   gap;
        int   span_a;
        int   span_b;

        vecs[0] = '{18'h1FFFF, 18'h20000, 2'd3, 32'h7FFF_8000, "sat_vol3"};
        vecs[1] = '{18'h00100, 18'h3FF00, 2'd2, 32'h0040_FFC0, "vol2"};
        vecs[2] = '{18'h00100, 18'h3FF00, 2'd1, 32'h0020_FFE0, "vol1"};
        vecs[3] = '{18'h00100, 18'h3FF00, 2'd0, 32'h0000_0000, "vol0"};
        vecs[4] = '{18'h3FFFF, 18'h0FFFE, 2'd3, 32'hFFFF_7FFF, "edge_vol3"};

        reset_n       = 1'b0;
        ntscmode      = 1'b0;
        audio_l       = 18'h00100;
        audio_r       = 18'h3FF00;
        system_volume = 2'd3;

        #1;
        check_vec("rst_clk_audio", 32'(clk_audio), 32'd0);
        check_vec("rst_stb", 32'(sample_stb), 32'd0);
        check_vec("rst_word", audio_sample_word, 32'h0);
        check_vec("rst_muted", 32'(muted), 32'd1);

        step();
        step();
        reset_n = 1'b1;

        // Initial mute window on the PAL modulus; input would give 0x0080FF80 if unmuted.
        last_stb = 0;
        span_a   = 0;
        span_b   = 0;
        for (int k = 1; k <= 64; k++) begin
            wait_stb("pal");
            gap = cyc - last_stb;
            last_stb = cyc;
            if (k >= 2) check_vec("pal_gap", 32'(gap), 32'(clamp(gap, 656, 657)));
            if (k == 21) span_a = cyc;
            if (k == 41) span_b = cyc;
            step();
            check_vec("mute_flag", 32'(muted), (k < 64) ? 32'd1 : 32'd0);
            wait_fall("pal");
            check_vec("mute_word", audio_sample_word, (k < 64) ? 32'h0 : 32'h0080_FF80);
        end
        check_vec("pal_span20", 32'(span_b - span_a), 32'(clamp(span_b - span_a, 13136, 13137)));

        // Datapath vectors; each word is captured on the fall after a fresh rise.
        foreach (vecs[i]) begin
            audio_l       = vecs[i].l;
            audio_r       = vecs[i].r;
            system_volume = vecs[i].vol;
            wait_stb(vecs[i].tag);
            wait_fall(vecs[i].tag);
            check_vec(vecs[i].tag, audio_sample_word, vecs[i].word);
        end
        wait_stb("hold");
        check_vec("hold_rise", audio_sample_word, 32'hFFFF_7FFF);
        wait_fall("hold");
        check_vec("hold_recap", audio_sample_word, 32'hFFFF_7FFF);

        // Mode change mid-run: restart phase and mute window on the NTSC modulus.
        ntscmode = 1'b1;
        step();
        check_vec("chg_acc", 32'(dut.acc), 32'd0);
        check_vec("chg_muted", 32'(muted), 32'd1);
        last_stb = 0;
        for (int k = 1; k <= 12; k++) begin
            wait_stb("ntsc");
            gap = cyc - last_stb;
            last_stb = cyc;
            if (k >= 2) check_vec("ntsc_gap", 32'(gap), 32'(clamp(gap, 681, 682)));
            if (k == 2)  span_a = cyc;
            if (k == 12) span_b = cyc;
            check_vec("ntsc_acc_lt_mod", 32'(dut.acc < 27'd32_727_264), 32'd1);
            wait_fall("ntsc");
            check_vec("chg_word", audio_sample_word, 32'h0);
            check_vec("chg_muted_hold", 32'(muted), 32'd1);
        end
        check_vec("ntsc_span10", 32'(span_b - span_a), 32'(clamp(span_b - span_a, 6818, 6819)));
        check_vec("chg_mute_cnt", 32'(dut.mute_cnt), 32'd52);

        // Asynchronous reset between a fall and the next rise, away from any clk edge.
        repeat (20) step();
        #2;
        reset_n = 1'b0;
        #1;
        check_vec("arst_word", audio_sample_word, 32'h0);
        check_vec("arst_clk_audio", 32'(clk_audio), 32'd0);
        check_vec("arst_muted", 32'(muted), 32'd1);
        check_vec("arst_stb", 32'(sample_stb), 32'd0);
        check_vec("arst_acc", 32'(dut.acc), 32'd0);
        check_vec("arst_mute_cnt", 32'(dut.mute_cnt), 32'd64);
        check_vec("arst_pipe", 32'(dut.u_sat_l.a17_q), 32'd0);
        #1;
        reset_n = 1'b1;

        // First clock after reset only samples ntscmode; the accumulator must keep counting.
        repeat (3) step();
        check_vec("post_rst_acc", 32'(dut.acc), 32'd288000);
        check_vec("post_rst_ntsc_q", 32'(dut.ntsc_q), 32'd1);
        check_vec("post_rst_muted", 32'(muted), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
